// File: rtl/ahmes_pkg.sv
// Shared encodings for the Ahmes control path: opcodes, ALU operations, FSM states, instruction classes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahmes_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_STA = 8'h10;
    localparam logic [7:0] OP_LDA = 8'h20;
    localparam logic [7:0] OP_ADD = 8'h30;
    localparam logic [7:0] OP_OR  = 8'h40;
    localparam logic [7:0] OP_AND = 8'h50;
    localparam logic [7:0] OP_NOT = 8'h60;
    localparam logic [7:0] OP_SUB = 8'h70;
    localparam logic [7:0] OP_JMP = 8'h80;
    localparam logic [7:0] OP_JN  = 8'h90;
    localparam logic [7:0] OP_JP  = 8'h94;
    localparam logic [7:0] OP_JV  = 8'h98;
    localparam logic [7:0] OP_JNV = 8'h9C;
    localparam logic [7:0] OP_JZ  = 8'hA0;
    localparam logic [7:0] OP_JNZ = 8'hA4;
    localparam logic [7:0] OP_JC  = 8'hB0;
    localparam logic [7:0] OP_JNC = 8'hB4;
    localparam logic [7:0] OP_JB  = 8'hB8;
    localparam logic [7:0] OP_JNB = 8'hBC;
    localparam logic [7:0] OP_SHR = 8'hE0;
    localparam logic [7:0] OP_SHL = 8'hE1;
    localparam logic [7:0] OP_ROR = 8'hE2;
    localparam logic [7:0] OP_ROL = 8'hE3;
    localparam logic [7:0] OP_HLT = 8'hF0;

    typedef enum logic [3:0] {
        ULA_ADD    = 4'd0,
        ULA_SUB    = 4'd1,
        ULA_OR     = 4'd2,
        ULA_AND    = 4'd3,
        ULA_NOT    = 4'd4,
        ULA_SHR    = 4'd5,
        ULA_SHL    = 4'd6,
        ULA_ROR    = 4'd7,
        ULA_ROL    = 4'd8,
        ULA_PASS_B = 4'd9
    } ula_op_t;

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_MEM_ALU = 3'd1,
        CLS_STA     = 3'd2,
        CLS_UNARY   = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_HLT     = 3'd5
    } instr_class_t;

    // Shift/rotate family encodes its operation in the two low opcode bits.
    function automatic ula_op_t shift_op(input logic [1:0] sel);
        case (sel)
            2'd0:    return ULA_SHR;
            2'd1:    return ULA_SHL;
            2'd2:    return ULA_ROR;
            default: return ULA_ROL;
        endcase
    endfunction

endpackage

// File: rtl/ahmes_decoder.sv
// Instruction decoder: classifies ri_out, picks the ALU operation and evaluates the jump condition.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs track inputs every cycle.
module ahmes_decoder
    import ahmes_pkg::*;
(
    input  logic [7:0]   ri_out,
    input  logic         flag_n,
    input  logic         flag_z,
    input  logic         flag_v,
    input  logic         flag_c,
    input  logic         flag_b,
    output instr_class_t instr_class,
    output ula_op_t      ula_op,
    output logic         jump_taken
);

    always_comb begin
        instr_class = CLS_NOP;
        ula_op      = ULA_ADD;
        jump_taken  = 1'b0;
        case (ri_out[7:4])
            4'h1: instr_class = CLS_STA;
            4'h2: begin
                instr_class = CLS_MEM_ALU;
                ula_op      = ULA_PASS_B;
            end
            4'h3: begin
                instr_class = CLS_MEM_ALU;
                ula_op      = ULA_ADD;
            end
            4'h4: begin
                instr_class = CLS_MEM_ALU;
                ula_op      = ULA_OR;
            end
            4'h5: begin
                instr_class = CLS_MEM_ALU;
                ula_op      = ULA_AND;
            end
            4'h6: begin
                instr_class = CLS_UNARY;
                ula_op      = ULA_NOT;
            end
            4'h7: begin
                instr_class = CLS_MEM_ALU;
                ula_op      = ULA_SUB;
            end
            4'h8: begin
                instr_class = CLS_JUMP;
                jump_taken  = 1'b1;
            end
            // Bit 2 inverts the sense of every conditional jump.
            4'h9: begin
                instr_class = CLS_JUMP;
                jump_taken  = (ri_out[3] ? flag_v : flag_n) ^ ri_out[2];
            end
            4'hA: begin
                if (!ri_out[3]) begin
                    instr_class = CLS_JUMP;
                    jump_taken  = flag_z ^ ri_out[2];
                end
            end
            4'hB: begin
                instr_class = CLS_JUMP;
                jump_taken  = (ri_out[3] ? flag_b : flag_c) ^ ri_out[2];
            end
            4'hE: begin
                instr_class = CLS_UNARY;
                ula_op      = shift_op(ri_out[1:0]);
            end
            4'hF: instr_class = CLS_HLT;
            default: instr_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/ahmes_control_unit.sv
// Fetch/decode/execute sequencer driving every datapath strobe of the Ahmes core.
// Latency: 4 cycles for NOP/unary/untaken jump, 6 for taken jump, 8 for memory-operand ops.
// Backpressure: none; memory reads are fixed one-cycle, HLT parks until reset.
module ahmes_control_unit
    import ahmes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ri_out,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_v,
    input  logic       flag_c,
    input  logic       flag_b,
    output logic       load_rem,
    output logic       load_rdm,
    output logic       load_ri,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       sel_rem,
    output logic       sel_rdm,
    output logic       mem_write,
    output ula_op_t    ula_op,
    output logic       load_nz,
    output logic       load_v,
    output logic       load_c,
    output logic       load_b,
    output logic       halted
);

    state_t       state;
    state_t       state_nxt;
    instr_class_t dec_class;
    ula_op_t      dec_ula;
    logic         dec_taken;

    ahmes_decoder u_decoder (
        .ri_out      (ri_out),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .flag_v      (flag_v),
        .flag_c      (flag_c),
        .flag_b      (flag_b),
        .instr_class (dec_class),
        .ula_op      (dec_ula),
        .jump_taken  (dec_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_T0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_rem  = 1'b0;
        load_rdm  = 1'b0;
        load_ri   = 1'b0;
        load_pc   = 1'b0;
        inc_pc    = 1'b0;
        load_ac   = 1'b0;
        sel_rem   = 1'b0;
        sel_rdm   = 1'b0;
        mem_write = 1'b0;
        ula_op    = ULA_ADD;
        load_nz   = 1'b0;
        load_v    = 1'b0;
        load_c    = 1'b0;
        load_b    = 1'b0;
        halted    = 1'b0;

        case (state)
            S_T0: begin
                load_rem  = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                load_rdm  = 1'b1;
                inc_pc    = 1'b1;
                state_nxt = S_T2;
            end
            S_T2: begin
                load_ri   = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                state_nxt = S_T0;
                case (dec_class)
                    CLS_UNARY: begin
                        ula_op  = dec_ula;
                        load_ac = 1'b1;
                        load_nz = 1'b1;
                        load_c  = (dec_ula != ULA_NOT);
                    end
                    CLS_HLT: state_nxt = S_HALT;
                    CLS_JUMP: begin
                        // Untaken jumps only step PC past the operand byte.
                        if (dec_taken) begin
                            load_rem  = 1'b1;
                            state_nxt = S_T4;
                        end else begin
                            inc_pc = 1'b1;
                        end
                    end
                    CLS_MEM_ALU, CLS_STA: begin
                        load_rem  = 1'b1;
                        state_nxt = S_T4;
                    end
                    default: state_nxt = S_T0;
                endcase
            end
            S_T4: begin
                // Only untaken-jump paths reach S_T0 from S_T3, so CLS_JUMP here means taken.
                load_rdm  = 1'b1;
                inc_pc    = (dec_class != CLS_JUMP);
                state_nxt = S_T5;
            end
            S_T5: begin
                if (dec_class == CLS_JUMP) begin
                    load_pc   = 1'b1;
                    state_nxt = S_T0;
                end else begin
                    load_rem  = 1'b1;
                    sel_rem   = 1'b1;
                    state_nxt = S_T6;
                end
            end
            S_T6: begin
                load_rdm  = 1'b1;
                sel_rdm   = (dec_class == CLS_STA);
                state_nxt = S_T7;
            end
            S_T7: begin
                state_nxt = S_T0;
                if (dec_class == CLS_STA) begin
                    mem_write = 1'b1;
                end else if (dec_class == CLS_MEM_ALU) begin
                    ula_op  = dec_ula;
                    load_ac = 1'b1;
                    load_nz = 1'b1;
                    load_v  = (dec_ula == ULA_ADD) || (dec_ula == ULA_SUB);
                    load_c  = (dec_ula == ULA_ADD);
                    load_b  = (dec_ula == ULA_SUB);
                end
            end
            S_HALT: begin
                halted    = 1'b1;
                state_nxt = S_HALT;
            end
            default: state_nxt = S_T0;
        endcase

        // Reset cycle issues nothing, so an aborted instruction leaves no side effect.
        if (reset) begin
            load_rem  = 1'b0;
            load_rdm  = 1'b0;
            load_ri   = 1'b0;
            load_pc   = 1'b0;
            inc_pc    = 1'b0;
            load_ac   = 1'b0;
            sel_rem   = 1'b0;
            sel_rdm   = 1'b0;
            mem_write = 1'b0;
            ula_op    = ULA_ADD;
            load_nz   = 1'b0;
            load_v    = 1'b0;
            load_c    = 1'b0;
            load_b    = 1'b0;
            halted    = 1'b0;
        end
    end

endmodule

// File: tb/tb_ahmes_control_unit.sv
// Bench for ahmes_control_unit: random and directed instruction streams against a per-instruction strobe timeline model.
module tb_ahmes_control_unit;
    import ahmes_pkg::*;

    typedef struct packed {
        logic       load_rem;
        logic       load_rdm;
        logic       load_ri;
        logic       load_pc;
        logic       inc_pc;
        logic       load_ac;
        logic       sel_rem;
        logic       sel_rdm;
        logic       mem_write;
        logic       load_nz;
        logic       load_v;
        logic       load_c;
        logic       load_b;
        logic       halted;
        logic [3:0] ula;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ri_out;
    logic [4:0] flags;
    logic       load_rem, load_rdm, load_ri, load_pc, inc_pc, load_ac;
    logic       sel_rem, sel_rdm, mem_write;
    ula_op_t    ula_op;
    logic       load_nz, load_v, load_c, load_b, halted;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t exp_q[$];

    logic [7:0] op_tab [0:25] = '{
        8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
        8'h90, 8'h94, 8'h98, 8'h9C, 8'hA0, 8'hA4, 8'hB0, 8'hB4, 8'hB8,
        8'hBC, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hC5, 8'hD3, 8'hA8
    };

    always #5 clk = ~clk;

    ahmes_control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ri_out    (ri_out),
        .flag_n    (flags[4]),
        .flag_z    (flags[3]),
        .flag_v    (flags[2]),
        .flag_c    (flags[1]),
        .flag_b    (flags[0]),
        .load_rem  (load_rem),
        .load_rdm  (load_rdm),
        .load_ri   (load_ri),
        .load_pc   (load_pc),
        .inc_pc    (inc_pc),
        .load_ac   (load_ac),
        .sel_rem   (sel_rem),
        .sel_rdm   (sel_rdm),
        .mem_write (mem_write),
        .ula_op    (ula_op),
        .load_nz   (load_nz),
        .load_v    (load_v),
        .load_c    (load_c),
        .load_b    (load_b),
        .halted    (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Selects and ALU op only matter while their register enable is active.
    function automatic vec_t observed();
        vec_t v;
        v.load_rem  = load_rem;
        v.load_rdm  = load_rdm;
        v.load_ri   = load_ri;
        v.load_pc   = load_pc;
        v.inc_pc    = inc_pc;
        v.load_ac   = load_ac;
        v.sel_rem   = sel_rem & load_rem;
        v.sel_rdm   = sel_rdm & load_rdm;
        v.mem_write = mem_write;
        v.load_nz   = load_nz;
        v.load_v    = load_v;
        v.load_c    = load_c;
        v.load_b    = load_b;
        v.halted    = halted;
        v.ula       = load_ac ? 4'(ula_op) : 4'd0;
        return v;
    endfunction

    // Expected strobe timeline of one instruction, starting at its fetch cycle.
    task automatic build_expect(input logic [7:0] op, input logic [4:0] fl);
        vec_t v;
        logic is_jump, taken;
        exp_q.delete();
        v = '0; v.load_rem = 1'b1;                   exp_q.push_back(v);
        v = '0; v.load_rdm = 1'b1; v.inc_pc = 1'b1;  exp_q.push_back(v);
        v = '0; v.load_ri = 1'b1;                    exp_q.push_back(v);
        is_jump = 1'b1;
        taken   = 1'b0;
        case (op)
            8'h80: taken = 1'b1;
            8'h90: taken = fl[4];
            8'h94: taken = !fl[4];
            8'h98: taken = fl[2];
            8'h9C: taken = !fl[2];
            8'hA0: taken = fl[3];
            8'hA4: taken = !fl[3];
            8'hB0: taken = fl[1];
            8'hB4: taken = !fl[1];
            8'hB8: taken = fl[0];
            8'hBC: taken = !fl[0];
            default: is_jump = 1'b0;
        endcase
        v = '0;
        if (is_jump) begin
            if (taken) begin
                v.load_rem = 1'b1; exp_q.push_back(v);
                v = '0; v.load_rdm = 1'b1; exp_q.push_back(v);
                v = '0; v.load_pc = 1'b1;  exp_q.push_back(v);
            end else begin
                v.inc_pc = 1'b1; exp_q.push_back(v);
            end
        end else begin
            case (op)
                8'h60, 8'hE0, 8'hE1, 8'hE2, 8'hE3: begin
                    v.load_ac = 1'b1;
                    v.load_nz = 1'b1;
                    v.load_c  = (op != 8'h60);
                    case (op)
                        8'h60:   v.ula = ULA_NOT;
                        8'hE0:   v.ula = ULA_SHR;
                        8'hE1:   v.ula = ULA_SHL;
                        8'hE2:   v.ula = ULA_ROR;
                        default: v.ula = ULA_ROL;
                    endcase
                    exp_q.push_back(v);
                end
                8'hF0: begin
                    exp_q.push_back(v);
                    v.halted = 1'b1;
                    repeat (20) exp_q.push_back(v);
                end
                8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h70: begin
                    v.load_rem = 1'b1; exp_q.push_back(v);
                    v = '0; v.load_rdm = 1'b1; v.inc_pc = 1'b1;  exp_q.push_back(v);
                    v = '0; v.load_rem = 1'b1; v.sel_rem = 1'b1; exp_q.push_back(v);
                    v = '0; v.load_rdm = 1'b1; v.sel_rdm = (op == 8'h10); exp_q.push_back(v);
                    v = '0;
                    if (op == 8'h10) begin
                        v.mem_write = 1'b1;
                    end else begin
                        v.load_ac = 1'b1;
                        v.load_nz = 1'b1;
                        v.load_v  = (op == 8'h30) || (op == 8'h70);
                        v.load_c  = (op == 8'h30);
                        v.load_b  = (op == 8'h70);
                        case (op)
                            8'h20:   v.ula = ULA_PASS_B;
                            8'h30:   v.ula = ULA_ADD;
                            8'h40:   v.ula = ULA_OR;
                            8'h50:   v.ula = ULA_AND;
                            default: v.ula = ULA_SUB;
                        endcase
                    end
                    exp_q.push_back(v);
                end
                default: exp_q.push_back(v);
            endcase
        end
    endtask

    // Flags are scrambled every cycle except the decode cycle, where fl3 is presented.
    task automatic run_instr(input logic [7:0] op, input logic [4:0] fl3, input int ncyc);
        build_expect(op, fl3);
        for (int i = 0; i < exp_q.size() && i < ncyc; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (i >= 3) ri_out = op;
            if (i == 3) flags = fl3;
            else flags = 5'($urandom);
            @(negedge clk);
            check_eq($sformatf("op%02h_cyc%0d", op, i + 1), 32'(observed()), 32'(exp_q[i]));
        end
    endtask

    task automatic reset_cycle(input string tag);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        ri_out = 8'($urandom);
        flags  = 5'($urandom);
        @(negedge clk);
        check_eq(tag, 32'(observed()), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        ri_out = 8'h00;
        flags  = 5'd0;
        repeat (3) reset_cycle("reset_hold");

        run_instr(8'h30, 5'($urandom), 99);
        run_instr(8'hA0, 5'b01000, 99);
        run_instr(8'hA0, 5'b10111, 99);
        run_instr(8'h10, 5'($urandom), 99);
        run_instr(8'hC5, 5'($urandom), 99);
        run_instr(8'h20, 5'($urandom), 5);
        reset_cycle("reset_in_lda_t5");
        run_instr(8'h70, 5'($urandom), 99);

        for (int k = 0; k < 150; k++) begin
            run_instr(op_tab[$urandom_range(0, 25)], 5'($urandom), 99);
        end

        run_instr(8'hF0, 5'($urandom), 99);
        reset_cycle("reset_from_halt");
        run_instr(8'h40, 5'($urandom), 99);
        run_instr(8'hE3, 5'($urandom), 99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahmes_control_unit.md
# ahmes_control_unit

Sequencing FSM for the Ahmes 8-bit CPU datapath. Steps the fetch/decode/execute cycle and drives every load/select strobe for the PC, REM, RDM, RI, accumulator, status flags, ALU and memory write. It sits between the instruction register/flag registers and the datapath registers, including the accumulator's `load_ac`. It is the only source of datapath control in the core.

## Interface
- No parameters; opcode and ALU encodings are fixed in the package.
- `clk` in 1: single system clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `ri_out` in 8: current instruction register contents.
- `flag_n`, `flag_z`, `flag_v`, `flag_c`, `flag_b` in 1 each: registered status flags.
- `load_rem`, `load_rdm`, `load_ri`, `load_pc`, `inc_pc`, `load_ac` out 1 each: register enables.
- `sel_rem` out 1: REM source, 0 = PC, 1 = RDM.
- `sel_rdm` out 1: RDM source, 0 = memory data, 1 = AC.
- `mem_write` out 1: memory write strobe at address REM with data RDM.
- `ula_op` out 4 (`ula_op_t`): ALU operation applied to AC and RDM.
- `load_nz`, `load_v`, `load_c`, `load_b` out 1 each: flag register enables.
- `halted` out 1: high while in `S_HALT`.

## Operation
- Memory reads are synchronous. Data at REM is valid for `load_rdm` one cycle after REM is loaded.
- States: `S_T0` to `S_T7` and `S_HALT`. Outputs are a combinational decode of the state and `ri_out`, Moore-style.
- Fetch:
  - `S_T0`: `load_rem` with `sel_rem=0`.
  - `S_T1`: `load_rdm` with `sel_rdm=0`, plus `inc_pc`.
  - `S_T2`: `load_ri`.
- `S_T3` decodes `ri_out` (class is the high nibble, with low bits for jumps and shifts):
  - NOP (0x00) and unknown opcodes: no strobes, go to `S_T0`.
  - NOT 0x60: `ula_op=NOT`, `load_ac`, `load_nz`, go to `S_T0`.
  - SHR/SHL/ROR/ROL (0xE0 to 0xE3): matching `ula_op`, `load_ac`, `load_nz`, `load_c`, go to `S_T0`.
  - HLT 0xF0: go to `S_HALT`.
  - Conditional jump with condition false: `inc_pc` to skip the operand, go to `S_T0`.
  - JMP, or conditional jump with condition true: `load_rem` with `sel_rem=0`, go to `S_T4`.
  - STA/LDA/ADD/OR/AND/SUB: `load_rem` with `sel_rem=0`, go to `S_T4`.
- Jump conditions:
  - JN 0x90 / JP 0x94: N / !N.
  - JV 0x98 / JNV 0x9C: V / !V.
  - JZ 0xA0 / JNZ 0xA4: Z / !Z.
  - JC 0xB0 / JNC 0xB4: C / !C.
  - JB 0xB8 / JNB 0xBC: B / !B.
- Jump taken: `S_T4` asserts `load_rdm`. `S_T5` asserts `load_pc` (PC <= RDM), then goes to `S_T0`.
- Memory-operand instructions:
  - `S_T4`: `load_rdm` and `inc_pc`.
  - `S_T5`: `load_rem` with `sel_rem=1`.
  - `S_T6`: `load_rdm`, with `sel_rdm=1` for STA and `sel_rdm=0` otherwise.
  - `S_T7`, STA: `mem_write`.
  - `S_T7`, LDA: `ula_op=PASS_B`, `load_ac`, `load_nz`.
  - `S_T7`, OR/AND: `load_ac`, `load_nz`.
  - `S_T7`, ADD: `load_ac`, `load_nz`, `load_v`, `load_c`.
  - `S_T7`, SUB: `load_ac`, `load_nz`, `load_v`, `load_b`.
  - All `S_T7` cases then go to `S_T0`.
- `S_HALT`: all strobes 0, `halted=1`. It is left only by reset.
- At most one of `load_pc` and `inc_pc` is active in any cycle.

## Timing
- Reset is synchronous: state becomes `S_T0` on the first edge with `reset=1`. While `reset=1`, all outputs are forced to 0, including `halted`.
- Reset mid-instruction aborts the instruction. No strobe is issued in the reset cycle, and fetch restarts from `S_T0` on the first cycle after reset deasserts.
- Cycle counts, measured `S_T0` to the next `S_T0`:
  - NOP, NOT, shifts, jump not taken: 4 cycles.
  - Jump taken: 6 cycles.
  - STA/LDA/ADD/OR/AND/SUB: 8 cycles.
  - HLT: 4 cycles to reach `S_HALT`.
- Flags are sampled in `S_T3` only. Flags written by the previous instruction's `S_T7` or `S_T3` are already registered at that point.

## Structure
- `ahmes_pkg` contents:
  - Opcode constants.
  - `ula_op_t` enum: ADD, SUB, OR, AND, NOT, SHR, SHL, ROR, ROL, PASS_B.
  - `state_t` enum.
  - `instr_class_t` enum: NOP, MEM_ALU, STA, UNARY, JUMP, HLT.
- Sub-module `ahmes_decoder` (combinational): maps `ri_out` and the flags to `instr_class_t`, `ula_op` and `jump_taken`. The FSM itself stays in `ahmes_control_unit`.

## Test plan
- Reset held 3 cycles, then released: all strobes 0 during reset; `load_rem=1` with `sel_rem=0` on the first cycle after release.
- `ri_out=0x30` (ADD): fetch, then `S_T7` asserts `load_ac`, `load_nz`, `load_v`, `load_c` with `ula_op=ADD` on cycle 8; `load_b=0`.
- `ri_out=0xA0`, `flag_z=1`: `load_pc` asserted in cycle 6. With `flag_z=0`: `inc_pc` in cycle 4 and fetch restarts in cycle 5.
- `ri_out=0x10` (STA): `sel_rdm=1` with `load_rdm` in `S_T6`, and `mem_write=1` exactly once in `S_T7`; `load_ac=0` throughout.
- `ri_out=0xF0`: `halted=1` from cycle 5 and no strobes for 20 cycles; reset returns `halted` to 0 and fetch resumes.
- `ri_out=0xC5` (unknown): behaves as NOP, 4 cycles with no datapath strobe outside fetch; reset asserted in `S_T5` of an LDA produces no `load_ac`.
